// File: rtl/addr_arbiter_pkg.sv
// Shared types and constants for the two-requester address arbiter.
// Owner tags travel through the datapath-latency pipeline as tag_t records.
package addr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic REQ_FETCH  = 1'b0;
    localparam logic REQ_OPND   = 1'b1;
    localparam int   DEFAULT_AW = 4;

    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;

endpackage

// File: rtl/addr_arbiter_tag_delay.sv
// LAT-deep {valid, owner} shift register that lines owner tags up with the
// datapath's delayed addr output.
module tag_delay
    import addr_arbiter_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_owner,
    output logic out_valid,
    output logic out_owner
);

    tag_t [LAT-1:0] stage_q;
    tag_t [LAT-1:0] stage_d;

    // Idle cycles keep carrying the most recent owner so tag_owner stays stable.
    always_comb begin
        stage_d          = stage_q;
        stage_d[0].valid = in_valid;
        stage_d[0].owner = in_valid ? in_owner : stage_q[0].owner;
        for (int i = 1; i < LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_valid = stage_q[LAT-1].valid;
    assign out_owner = stage_q[LAT-1].owner;

endmodule

// File: rtl/addr_arbiter.sv
// Round-robin, burst-limited arbiter between the fetch and operand address
// ports; drives datapath D0/D1/ctl and an owner tag aligned with its addr.
module addr_arbiter
    import addr_arbiter_pkg::*;
#(
    parameter int AW    = DEFAULT_AW,
    parameter int LAT   = 3,
    parameter int BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [AW-1:0] d0,
    output logic [AW-1:0] d1,
    output logic          ctl,
    output logic          tag_valid,
    output logic          tag_owner,
    output logic [1:0]    dbg_state
);

    localparam int            CW      = $clog2(BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST);

    arb_state_e    state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] d0_q, d0_d;
    logic [AW-1:0] d1_q, d1_d;
    logic          ctl_q, ctl_d;
    logic          burst_done;
    logic          xfer;

    // An exhausted burst with the other side waiting becomes the switch cycle:
    // the owner is not granted again, so the hand-over costs exactly one cycle.
    assign burst_done = (cnt_q == CNT_MAX);
    assign gnt0 = req0 & (state_q == OWN0) & ~(burst_done & req1);
    assign gnt1 = req1 & (state_q == OWN1) & ~(burst_done & req0);
    assign xfer = gnt0 | gnt1;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        ctl_d   = ctl_q;

        if (gnt0) begin
            d0_d   = addr0;
            ctl_d  = REQ_FETCH;
            last_d = REQ_FETCH;
        end
        if (gnt1) begin
            d1_d   = addr1;
            ctl_d  = REQ_OPND;
            last_d = REQ_OPND;
        end
        if (xfer && !burst_done) begin
            cnt_d = cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req0 && req1) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!req0) begin
                    cnt_d   = '0;
                    state_d = req1 ? OWN1 : IDLE;
                end else if (burst_done && req1) begin
                    cnt_d   = '0;
                    state_d = OWN1;
                end
            end
            OWN1: begin
                if (!req1) begin
                    cnt_d   = '0;
                    state_d = req0 ? OWN0 : IDLE;
                end else if (burst_done && req0) begin
                    cnt_d   = '0;
                    state_d = OWN0;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= REQ_OPND;
            cnt_q   <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
            ctl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            ctl_q   <= ctl_d;
        end
    end

    tag_delay #(.LAT(LAT)) u_tag_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (xfer),
        .in_owner  (gnt1),
        .out_valid (tag_valid),
        .out_owner (tag_owner)
    );

    assign d0        = d0_q;
    assign d1        = d1_q;
    assign ctl       = ctl_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_addr_arbiter.sv
// Cycle-vector bench for addr_arbiter: grants from a hand-derived table,
// D/ctl from a shadow model, owner tags through an expected queue.
module tb_addr_arbiter;
    import addr_arbiter_pkg::*;

    localparam int AW    = 4;
    localparam int LAT   = 3;
    localparam int BURST = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0  = 1'b0;
    logic          req1  = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic [AW-1:0] addr1 = '0;
    logic          gnt0, gnt1, ctl, tag_valid, tag_owner;
    logic [AW-1:0] d0, d1;
    logic [1:0]    dbg_state;

    addr_arbiter #(.AW(AW), .LAT(LAT), .BURST(BURST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .addr0     (addr0),
        .addr1     (addr1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .d0        (d0),
        .d1        (d1),
        .ctl       (ctl),
        .tag_valid (tag_valid),
        .tag_owner (tag_owner),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          r0;
        logic          r1;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic          g0;
        logic          g1;
    } vec_t;

    vec_t          vecs[$];
    vec_t          v;
    logic [1:0]    exp_q[$];
    logic [1:0]    t;
    logic [AW-1:0] cur_a0, cur_a1;
    logic [AW-1:0] exp_d0, exp_d1;
    logic          exp_ctl;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic add(input logic rst, input logic r0, input logic r1,
                       input logic g0, input logic g1);
        vec_t nv;
        nv.rst = rst;
        nv.r0  = r0;
        nv.r1  = r1;
        nv.a0  = cur_a0;
        nv.a1  = cur_a1;
        nv.g0  = g0;
        nv.g1  = g1;
        vecs.push_back(nv);
        if (g0) cur_a0 = AW'($urandom_range(15, 0));
        if (g1) cur_a1 = AW'($urandom_range(15, 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input int cyc, input string name,
                         input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL cycle %0d %s: got %0h expected %0h", cyc, name, act, exp);
        end
    endtask

    // Requester protocol: a pending address must not change until granted.
    logic          pend0_q = 1'b0, pend1_q = 1'b0;
    logic [AW-1:0] pa0_q = '0, pa1_q = '0;
    always @(posedge clk) begin
        if (rst_n && pend0_q && req0)
            assert (addr0 == pa0_q) else $error("addr0 changed while pending");
        if (rst_n && pend1_q && req1)
            assert (addr1 == pa1_q) else $error("addr1 changed while pending");
        pend0_q <= req0 & ~gnt0;
        pend1_q <= req1 & ~gnt1;
        pa0_q   <= addr0;
        pa1_q   <= addr1;
    end

    initial begin
        cur_a0 = '0;
        cur_a1 = '0;

        // reset, idle, reset again while idle
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // single fetch request, address A
        cur_a0 = 4'hA;
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(4);

        // fresh reset, then both request continuously
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        for (int k = 0; k <= 14; k++) begin
            add(1'b0, 1'b1, 1'b1,
                ((k >= 1 && k <= 4) || (k >= 11 && k <= 14)),
                (k >= 6 && k <= 9));
        end
        idle(4);

        // operand owner drops after two transfers; fetch burst restarts
        for (int k = 0; k <= 12; k++) begin
            add(1'b0, (k <= 11), ((k <= 2) || (k >= 5 && k <= 9)),
                ((k >= 4 && k <= 7) || k == 11),
                (k == 1 || k == 2 || k == 9));
        end
        idle(3);

        // reset with two tags in flight, then a fresh operand transfer
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(5);

        // lone owner beyond BURST (counter saturates), then the other arrives
        for (int k = 0; k <= 11; k++) begin
            add(1'b0, (k <= 10), (k == 7 || k == 8),
                ((k >= 1 && k <= 6) || k == 10), (k == 8));
        end
        idle(4);

        exp_d0  = '0;
        exp_d1  = '0;
        exp_ctl = 1'b0;
        for (int i = 0; i < LAT; i++) exp_q.push_back(2'b00);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
            rst_n = ~v.rst;
            req0  = v.r0;
            req1  = v.r1;
            addr0 = v.a0;
            addr1 = v.a1;
            #1;
            if (v.rst) begin
                exp_d0  = '0;
                exp_d1  = '0;
                exp_ctl = 1'b0;
                exp_q.delete();
                for (int j = 0; j < LAT; j++) exp_q.push_back(2'b00);
                check(i, "reset_state", 8'(dbg_state), 8'(IDLE));
                check(i, "reset_tag_owner", 8'(tag_owner), 8'h00);
            end
            check(i, "gnt0", 8'(gnt0), 8'(v.g0));
            check(i, "gnt1", 8'(gnt1), 8'(v.g1));
            check(i, "d0", 8'(d0), 8'(exp_d0));
            check(i, "d1", 8'(d1), 8'(exp_d1));
            check(i, "ctl", 8'(ctl), 8'(exp_ctl));
            t = exp_q.pop_front();
            check(i, "tag_valid", 8'(tag_valid), 8'(t[1]));
            if (t[1]) check(i, "tag_owner", 8'(tag_owner), 8'(t[0]));
            exp_q.push_back({v.g0 | v.g1, v.g1});
            if (v.g0) begin
                exp_d0  = v.a0;
                exp_ctl = 1'b0;
            end
            if (v.g1) begin
                exp_d1  = v.a1;
                exp_ctl = 1'b1;
            end
        end

        // asynchronous reset landing between clock edges
        @(negedge clk);
        req0  = 1'b1;
        addr0 = 4'h5;
        @(posedge clk);
        @(posedge clk);
        #1;
        check(-1, "async_pre_d0", 8'(d0), 8'h05);
        check(-1, "async_pre_ctl", 8'(ctl), 8'h00);
        #1 rst_n = 1'b0;
        #1;
        check(-1, "async_d0", 8'(d0), 8'h00);
        check(-1, "async_gnt0", 8'(gnt0), 8'h00);
        check(-1, "async_state", 8'(dbg_state), 8'(IDLE));
        check(-1, "async_tag_valid", 8'(tag_valid), 8'h00);
        @(negedge clk);
        req0  = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check(-1, "post_tag_valid", 8'(tag_valid), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
